// File: rtl/mpa_operand_streamer_pkg.sv
// Shared definitions for the multi-precision operand streamer:
// FSM state encoding, RAM read latency and default widths.
package mpa_streamer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    // Register-bank read data arrives this many cycles after the address
    localparam int c_rd_latency = 1;

    localparam int c_data_width = 64;
    localparam int c_addr_width = 9;

endpackage

// File: rtl/mpa_operand_streamer_if.sv
// Bus bundle of the operand streamer: command handshake, register-bank
// read ports and the word stream towards the adder.
// Optional MPA_STREAMER_WORD_CNT_EN adds the po_word_cnt status output.
interface mpa_operand_streamer_if import mpa_streamer_pkg::*; #(
    parameter int g_data_width = c_data_width,
    parameter int g_addr_width = c_addr_width
) ();

    logic                    pi_cmd_valid;
    logic [g_addr_width-1:0] pi_len_A;
    logic [g_addr_width-1:0] pi_len_B;
    logic                    po_cmd_ready;
    logic                    pi_abort;
    logic [g_addr_width-1:0] po_rd_addr_A;
    logic [g_addr_width-1:0] po_rd_addr_B;
    logic [g_data_width-1:0] pi_rd_data_A;
    logic [g_data_width-1:0] pi_rd_data_B;
    logic [g_data_width-1:0] po_data_A;
    logic [g_data_width-1:0] po_data_B;
    logic                    po_data_wr_en;
    logic                    po_data_last;
`ifdef MPA_STREAMER_WORD_CNT_EN
    logic [g_addr_width:0]   po_word_cnt;

    modport slave (
        input  pi_cmd_valid, pi_len_A, pi_len_B, pi_abort, pi_rd_data_A, pi_rd_data_B,
        output po_cmd_ready, po_rd_addr_A, po_rd_addr_B, po_data_A, po_data_B,
               po_data_wr_en, po_data_last, po_word_cnt
    );

    modport master (
        output pi_cmd_valid, pi_len_A, pi_len_B, pi_abort, pi_rd_data_A, pi_rd_data_B,
        input  po_cmd_ready, po_rd_addr_A, po_rd_addr_B, po_data_A, po_data_B,
               po_data_wr_en, po_data_last, po_word_cnt
    );
`else
    modport slave (
        input  pi_cmd_valid, pi_len_A, pi_len_B, pi_abort, pi_rd_data_A, pi_rd_data_B,
        output po_cmd_ready, po_rd_addr_A, po_rd_addr_B, po_data_A, po_data_B,
               po_data_wr_en, po_data_last
    );

    modport master (
        output pi_cmd_valid, pi_len_A, pi_len_B, pi_abort, pi_rd_data_A, pi_rd_data_B,
        input  po_cmd_ready, po_rd_addr_A, po_rd_addr_B, po_data_A, po_data_B,
               po_data_wr_en, po_data_last
    );
`endif

endinterface

// File: rtl/mpa_operand_streamer_channel.sv
// One operand channel: clamps the read address to the operand's last word,
// flags indices past the end as exhausted and substitutes zero words for them.
module mpa_operand_channel import mpa_streamer_pkg::*; #(
    parameter int g_data_width = c_data_width,
    parameter int g_addr_width = c_addr_width
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    flush_i,
    input  logic                    issue_i,
    input  logic [g_addr_width-1:0] idx_i,
    input  logic [g_addr_width-1:0] len_i,
    input  logic [g_data_width-1:0] rd_data_i,
    output logic [g_addr_width-1:0] rd_addr_o,
    output logic [g_data_width-1:0] data_o
);

    logic                    exhausted;
    logic [c_rd_latency-1:0] live_q, live_d;
    logic [g_data_width-1:0] data_q, data_d;

    assign exhausted = idx_i > len_i;
    assign rd_addr_o = exhausted ? len_i : idx_i;
    assign data_o    = data_q;

    // Track which issued reads carry real operand data until the RAM answers
    always_comb begin
        live_d    = live_q << 1;
        live_d[0] = issue_i && !exhausted;
        data_d    = live_q[c_rd_latency-1] ? rd_data_i : '0;
    end

    // Pipeline and output word register, emptied on abort
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            live_q <= '0;
            data_q <= '0;
        end else if (flush_i) begin
            live_q <= '0;
            data_q <= '0;
        end else begin
            live_q <= live_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/mpa_operand_streamer.sv
// Streams two multi-word operands, least significant word first, from a
// register bank to the adder, zero-padding the shorter operand.
// Optional MPA_STREAMER_WORD_CNT_EN adds po_word_cnt (words emitted this stream).
module mpa_operand_streamer import mpa_streamer_pkg::*; #(
    parameter int g_data_width = c_data_width,
    parameter int g_addr_width = c_addr_width
) (
    input  logic pi_clk,
    input  logic pi_rst_n,
    mpa_operand_streamer_if.slave bus
);

    state_e                  state_q, state_d;
    logic [g_addr_width-1:0] idx_q, idx_d;
    logic [g_addr_width-1:0] lenA_q, lenA_d;
    logic [g_addr_width-1:0] lenB_q, lenB_d;
    logic [g_addr_width-1:0] lastIdx_q, lastIdx_d;
    logic                    ready_q;
    logic                    accept, issue, issueLast, flush;
    logic [c_rd_latency-1:0] vldPipe_q, vldPipe_d;
    logic [c_rd_latency-1:0] lastPipe_q, lastPipe_d;
    logic                    wrEn_q, last_q;

    assign accept = (state_q == S_IDLE) && ready_q && bus.pi_cmd_valid;

    // Next state, word index and captured lengths
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lenA_d    = lenA_q;
        lenB_d    = lenB_q;
        lastIdx_d = lastIdx_q;
        issue     = 1'b0;
        issueLast = 1'b0;
        flush     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_READ;
                    idx_d     = '0;
                    lenA_d    = bus.pi_len_A;
                    lenB_d    = bus.pi_len_B;
                    lastIdx_d = (bus.pi_len_A > bus.pi_len_B) ? bus.pi_len_A : bus.pi_len_B;
                end
            end
            S_READ: begin
                if (bus.pi_abort) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    issue = 1'b1;
                    if (idx_q == lastIdx_q) begin
                        issueLast = 1'b1;
                        state_d   = S_FLUSH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (bus.pi_abort) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (last_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers; ready is low throughout reset and follows IDLE afterwards
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            lenA_q    <= '0;
            lenB_q    <= '0;
            lastIdx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lenA_q    <= lenA_d;
            lenB_q    <= lenB_d;
            lastIdx_q <= lastIdx_d;
            ready_q   <= (state_d == S_IDLE);
        end
    end

    // Delay the valid/last markers by the RAM latency to line up with the data
    always_comb begin
        vldPipe_d     = vldPipe_q << 1;
        vldPipe_d[0]  = issue;
        lastPipe_d    = lastPipe_q << 1;
        lastPipe_d[0] = issueLast;
    end

    // Registered word strobe and last flag, dropped immediately on abort
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            vldPipe_q  <= '0;
            lastPipe_q <= '0;
            wrEn_q     <= 1'b0;
            last_q     <= 1'b0;
        end else if (flush) begin
            vldPipe_q  <= '0;
            lastPipe_q <= '0;
            wrEn_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            vldPipe_q  <= vldPipe_d;
            lastPipe_q <= lastPipe_d;
            wrEn_q     <= vldPipe_q[c_rd_latency-1];
            last_q     <= lastPipe_q[c_rd_latency-1];
        end
    end

    mpa_operand_channel #(
        .g_data_width (g_data_width),
        .g_addr_width (g_addr_width)
    ) u_chan_a (
        .clk_i     (pi_clk),
        .rst_n_i   (pi_rst_n),
        .flush_i   (flush),
        .issue_i   (issue),
        .idx_i     (idx_q),
        .len_i     (lenA_q),
        .rd_data_i (bus.pi_rd_data_A),
        .rd_addr_o (bus.po_rd_addr_A),
        .data_o    (bus.po_data_A)
    );

    mpa_operand_channel #(
        .g_data_width (g_data_width),
        .g_addr_width (g_addr_width)
    ) u_chan_b (
        .clk_i     (pi_clk),
        .rst_n_i   (pi_rst_n),
        .flush_i   (flush),
        .issue_i   (issue),
        .idx_i     (idx_q),
        .len_i     (lenB_q),
        .rd_data_i (bus.pi_rd_data_B),
        .rd_addr_o (bus.po_rd_addr_B),
        .data_o    (bus.po_data_B)
    );

    assign bus.po_cmd_ready  = ready_q;
    assign bus.po_data_wr_en = wrEn_q;
    assign bus.po_data_last  = last_q;

`ifdef MPA_STREAMER_WORD_CNT_EN
    logic [g_addr_width:0] wordCnt_q, wordCnt_d;

    // Words emitted in the current stream; cleared on accept, held after the end
    always_comb begin
        wordCnt_d = accept ? '0 : wordCnt_q + {{g_addr_width{1'b0}}, wrEn_q};
    end

    // Word counter register
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            wordCnt_q <= '0;
        end else begin
            wordCnt_q <= wordCnt_d;
        end
    end

    assign bus.po_word_cnt = wordCnt_q;
`endif

endmodule

// File: tb/tb_mpa_operand_streamer.sv
// Self-checking bench for mpa_operand_streamer: a timeline model of the
// stream predicts every output each cycle, plus directed literal checks.
module tb_mpa_operand_streamer;

   localparam int DW   = 64;
   localparam int AW   = 9;
   localparam int NMAX = 1 << AW;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   mpa_operand_streamer_if #(.g_data_width(DW), .g_addr_width(AW)) bus();

   mpa_operand_streamer #(.g_data_width(DW), .g_addr_width(AW)) dut (
      .pi_clk   (clk),
      .pi_rst_n (rst_n),
      .bus      (bus)
   );

   logic [DW-1:0] ramA [NMAX];
   logic [DW-1:0] ramB [NMAX];

   int nChecks = 0;
   int nPass   = 0;

   logic [63:0] litA     [4] = '{64'h1, 64'h2, 64'h3, 64'h4};
   logic [63:0] litB     [4] = '{64'hA, 64'hB, 64'h0, 64'h0};
   logic [63:0] litAddrB [4] = '{64'd0, 64'd1, 64'd1, 64'd1};

   // Register bank: data one cycle after the address
   always @(posedge clk) begin
      bus.pi_rd_data_A <= ramA[bus.po_rd_addr_A];
      bus.pi_rd_data_B <= ramB[bus.po_rd_addr_B];
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: stream time d counts cycles since the accepting edge
   bit            mActive = 0, mReady = 0, mWrEn = 0, mLast = 0, mAddrValid = 0;
   int            mD = 0, mN = 1, mLenA = 0, mLenB = 0, mCnt = 0;
   logic [DW-1:0] mA = '0, mB = '0;
   logic [AW-1:0] mAddrA = '0, mAddrB = '0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mActive = 0; mReady = 0; mWrEn = 0; mLast = 0; mAddrValid = 0;
         mA = '0; mB = '0; mCnt = 0; mD = 0;
      end else begin
         if (mWrEn) mCnt++;
         if (mActive) mD++;
         if (mReady && bus.pi_cmd_valid) begin
            mActive = 1;
            mD      = 0;
            mLenA   = int'(bus.pi_len_A);
            mLenB   = int'(bus.pi_len_B);
            mN      = ((mLenA > mLenB) ? mLenA : mLenB) + 1;
            mCnt    = 0;
         end else if (mActive && bus.pi_abort) begin
            mActive = 0;
         end
         if (mActive && mD >= mN + 2) mActive = 0;
         mReady = !mActive;
         mWrEn = 0; mLast = 0; mA = '0; mB = '0; mAddrValid = 0;
         if (mActive) begin
            if (mD < mN) begin
               mAddrValid = 1;
               mAddrA = AW'((mD < mLenA) ? mD : mLenA);
               mAddrB = AW'((mD < mLenB) ? mD : mLenB);
            end
            if (mD >= 2 && mD <= mN + 1) begin
               int k;
               k     = mD - 2;
               mWrEn = 1;
               mLast = (k == mN - 1);
               mA    = (k <= mLenA) ? ramA[k] : '0;
               mB    = (k <= mLenB) ? ramB[k] : '0;
            end
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge
   initial forever begin
      @(negedge clk);
      checkOutput("ready", {63'd0, bus.po_cmd_ready}, {63'd0, mReady});
      checkOutput("wr_en", {63'd0, bus.po_data_wr_en}, {63'd0, mWrEn});
      checkOutput("last", {63'd0, bus.po_data_last}, {63'd0, mLast});
      checkOutput("data_A", bus.po_data_A, mA);
      checkOutput("data_B", bus.po_data_B, mB);
      if (mAddrValid) begin
         checkOutput("rd_addr_A", 64'(bus.po_rd_addr_A), 64'(mAddrA));
         checkOutput("rd_addr_B", 64'(bus.po_rd_addr_B), 64'(mAddrB));
      end
`ifdef MPA_STREAMER_WORD_CNT_EN
      checkOutput("word_cnt", 64'(bus.po_word_cnt), 64'(mCnt));
`endif
   end

   task automatic waitIdle();
      for (int i = 0; i < 2000 && !bus.po_cmd_ready; i++) tick();
      checkOutput("idle_wait", {63'd0, bus.po_cmd_ready}, 64'd1);
   endtask

   // Issue one command; returns in the cycle after the accept
   task automatic applyStimulus(input int la, input int lb);
      waitIdle();
      bus.pi_len_A     = AW'(la);
      bus.pi_len_B     = AW'(lb);
      bus.pi_cmd_valid = 1'b1;
      tick();
      bus.pi_cmd_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int wrCnt, lastCnt, firstC, lastC, maxAddr;
      bit found;
      bus.pi_cmd_valid = 1'b0;
      bus.pi_abort     = 1'b0;
      bus.pi_len_A     = '0;
      bus.pi_len_B     = '0;
      for (int i = 0; i < NMAX; i++) begin
         ramA[i] = {$urandom, $urandom};
         ramB[i] = {$urandom, $urandom};
      end

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ready", {63'd0, bus.po_cmd_ready}, 64'd0);
      checkOutput("rst_wr_en", {63'd0, bus.po_data_wr_en}, 64'd0);
      checkOutput("rst_last", {63'd0, bus.po_data_last}, 64'd0);
      checkOutput("rst_addr_A", 64'(bus.po_rd_addr_A), 64'd0);
      checkOutput("rst_data_A", bus.po_data_A, 64'd0);
      rst_n = 1'b1;
      tick();
      checkOutput("rel_ready", {63'd0, bus.po_cmd_ready}, 64'd1);

      // single-word stream
      applyStimulus(0, 0);
      tick(); tick();
      checkOutput("single_wr_en_c3", {63'd0, bus.po_data_wr_en}, 64'd1);
      checkOutput("single_last_c3", {63'd0, bus.po_data_last}, 64'd1);
      checkOutput("single_ready_c3", {63'd0, bus.po_cmd_ready}, 64'd0);
      tick();
      checkOutput("single_ready_c4", {63'd0, bus.po_cmd_ready}, 64'd1);
      checkOutput("single_wr_en_c4", {63'd0, bus.po_data_wr_en}, 64'd0);

      // unequal lengths with zero padding of B
      for (int i = 0; i < 4; i++) ramA[i] = 64'(i + 1);
      ramB[0] = 64'hA; ramB[1] = 64'hB; ramB[2] = 64'hDEAD; ramB[3] = 64'hBEEF;
      applyStimulus(3, 1);
      for (int c = 1; c <= 6; c++) begin
         if (c <= 4) checkOutput("pad_addr_B", 64'(bus.po_rd_addr_B), litAddrB[c-1]);
         if (c >= 3) begin
            checkOutput("pad_wr_en", {63'd0, bus.po_data_wr_en}, 64'd1);
            checkOutput("pad_data_A", bus.po_data_A, litA[c-3]);
            checkOutput("pad_data_B", bus.po_data_B, litB[c-3]);
            checkOutput("pad_last", {63'd0, bus.po_data_last}, (c == 6) ? 64'd1 : 64'd0);
         end
         if (c < 6) tick();
      end

      // maximum length stream
      applyStimulus(NMAX - 1, NMAX - 1);
      wrCnt = 0; lastCnt = 0; firstC = -1; lastC = -1; maxAddr = 0;
      for (int c = 1; c <= 540; c++) begin
         if (bus.po_data_wr_en) begin
            wrCnt++;
            if (firstC < 0) firstC = c;
            lastC = c;
         end
         if (bus.po_data_last) lastCnt++;
         if (int'(bus.po_rd_addr_A) > maxAddr) maxAddr = int'(bus.po_rd_addr_A);
         tick();
      end
      checkOutput("max_wr_count", 64'(wrCnt), 64'd512);
      checkOutput("max_last_count", 64'(lastCnt), 64'd1);
      checkOutput("max_contiguous", 64'(lastC - firstC), 64'd511);
      checkOutput("max_addr_top", 64'(maxAddr), 64'd511);

      // abort right after the 5th word
      applyStimulus(20, int'($urandom_range(0, 20)));
      repeat (6) tick();
      checkOutput("abort_word5", {63'd0, bus.po_data_wr_en}, 64'd1);
      bus.pi_abort = 1'b1;
      tick();
      bus.pi_abort = 1'b0;
      checkOutput("abort_wr_en", {63'd0, bus.po_data_wr_en}, 64'd0);
      checkOutput("abort_last", {63'd0, bus.po_data_last}, 64'd0);
      checkOutput("abort_ready", {63'd0, bus.po_cmd_ready}, 64'd1);
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      lastCnt = 0;
      for (int c = 1; c <= 40; c++) begin
         if (bus.po_data_last) lastCnt++;
         tick();
      end
      checkOutput("after_abort_last", 64'(lastCnt), 64'd1);

      // reset during word 2 of a 10-word stream
      applyStimulus(9, 9);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_wr_en", {63'd0, bus.po_data_wr_en}, 64'd0);
      checkOutput("midrst_last", {63'd0, bus.po_data_last}, 64'd0);
      checkOutput("midrst_data_A", bus.po_data_A, 64'd0);
      checkOutput("midrst_ready", {63'd0, bus.po_cmd_ready}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      checkOutput("midrst_rel_ready", {63'd0, bus.po_cmd_ready}, 64'd1);
      wrCnt = 0;
      for (int c = 0; c < 15; c++) begin
         if (bus.po_data_wr_en) wrCnt++;
         tick();
      end
      checkOutput("midrst_no_residual", 64'(wrCnt), 64'd0);

      // cmd_valid held high across back-to-back streams
      waitIdle();
      bus.pi_len_A     = AW'(4);
      bus.pi_len_B     = AW'(2);
      bus.pi_cmd_valid = 1'b1;
      for (int s = 0; s < 3; s++) begin
         found = 0;
         for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.po_data_last) found = 1;
         end
         checkOutput("held_last_seen", {63'd0, found}, 64'd1);
         tick();
         checkOutput("held_ready", {63'd0, bus.po_cmd_ready}, 64'd1);
`ifdef MPA_STREAMER_WORD_CNT_EN
         checkOutput("held_word_cnt", 64'(bus.po_word_cnt), 64'd5);
`endif
      end
      bus.pi_cmd_valid = 1'b0;

      // randomized commands, lengths, aborts and idle-time aborts
      for (int c = 0; c < 1500; c++) begin
         bus.pi_cmd_valid = ($urandom % 3) == 0;
         bus.pi_len_A     = AW'($urandom_range(0, 24));
         bus.pi_len_B     = AW'($urandom_range(0, 24));
         bus.pi_abort     = ($urandom % 30) == 0;
         tick();
      end
      bus.pi_cmd_valid = 1'b0;
      bus.pi_abort     = 1'b0;
      waitIdle();
      repeat (3) tick();

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
